// File: rtl/udp_packet_generator_pkg.sv
// Shared types and helpers for the UDP packet generator: FSM state encoding,
// header size, payload length clamp and the payload byte pattern.
package udp_gen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    GAP     = 2'd3
  } udp_gen_state_t;

  localparam logic [15:0] UDP_HDR_BYTES = 16'd8;

  function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                            input logic [15:0] lo,
                                            input logic [15:0] hi);
    logic [15:0] r;
    if (len < lo) begin
      r = lo;
    end else if (len > hi) begin
      r = hi;
    end else begin
      r = len;
    end
    return r;
  endfunction

  // First four bytes carry the sequence number MSB first, then a wrapping index.
  function automatic logic [7:0] payload_byte(input logic [15:0] idx,
                                              input logic [31:0] seq);
    logic [7:0] r;
    case (idx)
      16'd0:   r = seq[31:24];
      16'd1:   r = seq[23:16];
      16'd2:   r = seq[15:8];
      16'd3:   r = seq[7:0];
      default: r = idx[7:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/udp_packet_generator.sv
// Originating UDP transmitter: emits a header then a sequence-numbered payload
// stream, repeating with a configurable idle gap while enable is held high.
module udp_packet_generator
  import udp_gen_pkg::*;
#(
  parameter logic [31:0] SRC_IP      = 32'hC0A80180,
  parameter logic [7:0]  TTL         = 8'd64,
  parameter logic [15:0] MAX_PAYLOAD = 16'd1472,
  parameter logic [15:0] MIN_PAYLOAD = 16'd4
) (
  input  logic        udp_sys_clk,
  input  logic        system_reset_n,
  input  logic        enable,
  input  logic [31:0] cfg_dest_ip,
  input  logic [15:0] cfg_src_port,
  input  logic [15:0] cfg_dest_port,
  input  logic [15:0] cfg_payload_len,
  input  logic [15:0] cfg_gap_cycles,
  output logic        udp_hdr_valid,
  input  logic        udp_hdr_ready,
  output logic [31:0] udp_ip_source_ip,
  output logic [31:0] udp_ip_dest_ip,
  output logic [15:0] udp_source_port,
  output logic [15:0] udp_dest_port,
  output logic [15:0] udp_length,
  output logic [5:0]  udp_ip_dscp,
  output logic [1:0]  udp_ip_ecn,
  output logic [7:0]  udp_ip_ttl,
  output logic [15:0] udp_checksum,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [31:0] tx_seq,
  output logic        busy
);

  udp_gen_state_t state_q, state_d;
  logic [31:0] dest_ip_q, dest_ip_d;
  logic [15:0] src_port_q, src_port_d;
  logic [15:0] dest_port_q, dest_port_d;
  logic [15:0] len_q, len_d;
  logic [15:0] udp_len_q, udp_len_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] tx_seq_q, tx_seq_d;
  logic        hdr_valid_q, tvalid_q, tlast_q, busy_q;
  logic        tlast_d;
  logic [7:0]  tdata_q, tdata_d;
  logic [15:0] clamped_s;
  logic        latch_s;

  assign clamped_s = clamp_len(cfg_payload_len, MIN_PAYLOAD, MAX_PAYLOAD);

  // Next-state logic: FSM transitions, config latch points, byte index and sequence.
  always_comb begin
    state_d     = state_q;
    dest_ip_d   = dest_ip_q;
    src_port_d  = src_port_q;
    dest_port_d = dest_port_q;
    len_d       = len_q;
    udp_len_d   = udp_len_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    idx_d       = idx_q;
    tx_seq_d    = tx_seq_q;
    latch_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          latch_s = 1'b1;
          state_d = HDR;
        end else begin
          state_d = IDLE;
        end
      end
      HDR: begin
        if (udp_hdr_ready) begin
          state_d = PAYLOAD;
          idx_d   = 16'd0;
        end else begin
          state_d = HDR;
        end
      end
      PAYLOAD: begin
        if (m_axis_tready && tlast_q) begin
          tx_seq_d  = tx_seq_q + 32'd1;
          state_d   = GAP;
          gap_cnt_d = (gap_q == 16'd0) ? 16'd1 : gap_q;
        end else if (m_axis_tready) begin
          idx_d = idx_q + 16'd1;
        end else begin
          idx_d = idx_q;
        end
      end
      GAP: begin
        // The counter holds the idle cycles still to spend, including this one.
        if (gap_cnt_q <= 16'd1) begin
          if (enable) begin
            latch_s = 1'b1;
            state_d = HDR;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (latch_s) begin
      dest_ip_d   = cfg_dest_ip;
      src_port_d  = cfg_src_port;
      dest_port_d = cfg_dest_port;
      len_d       = clamped_s;
      udp_len_d   = clamped_s + UDP_HDR_BYTES;
      gap_d       = cfg_gap_cycles;
    end else begin
      len_d = len_d;
    end
    if (state_d == PAYLOAD) begin
      tdata_d = payload_byte(idx_d, tx_seq_d);
      tlast_d = (idx_d == (len_d - 16'd1));
    end else begin
      tdata_d = 8'd0;
      tlast_d = 1'b0;
    end
  end

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge udp_sys_clk) begin
    if (!system_reset_n) begin
      state_q     <= IDLE;
      dest_ip_q   <= 32'd0;
      src_port_q  <= 16'd0;
      dest_port_q <= 16'd0;
      len_q       <= 16'd0;
      udp_len_q   <= 16'd0;
      gap_q       <= 16'd0;
      gap_cnt_q   <= 16'd0;
      idx_q       <= 16'd0;
      tx_seq_q    <= 32'd0;
      hdr_valid_q <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= 8'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dest_ip_q   <= dest_ip_d;
      src_port_q  <= src_port_d;
      dest_port_q <= dest_port_d;
      len_q       <= len_d;
      udp_len_q   <= udp_len_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      idx_q       <= idx_d;
      tx_seq_q    <= tx_seq_d;
      hdr_valid_q <= (state_d == HDR);
      tvalid_q    <= (state_d == PAYLOAD);
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign udp_hdr_valid    = hdr_valid_q;
  assign udp_ip_source_ip = SRC_IP;
  assign udp_ip_dest_ip   = dest_ip_q;
  assign udp_source_port  = src_port_q;
  assign udp_dest_port    = dest_port_q;
  assign udp_length       = udp_len_q;
  assign udp_ip_dscp      = 6'd0;
  assign udp_ip_ecn       = 2'd0;
  assign udp_ip_ttl       = TTL;
  assign udp_checksum     = 16'd0;
  assign m_axis_tdata     = tdata_q;
  assign m_axis_tvalid    = tvalid_q;
  assign m_axis_tlast     = tlast_q;
  assign m_axis_tuser     = 1'b0;
  assign tx_seq           = tx_seq_q;
  assign busy             = busy_q;

endmodule
